// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants and types for the 8-digit seven-segment scanner.
//
// Contents:
//   NUM_DIGITS   number of multiplexed digits on the display
//   PRESC_W      width of the per-digit prescaler (covers CLK_DIV up to 2^20)
//   SEG_0..SEG_F active-low {g,f,e,d,c,b,a} patterns for hex digits
//   SEG_BLANK    all segments off
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int PRESC_W    = 20;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;
  typedef logic [2:0] digit_idx_t;

  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational hex nibble to active-low seven-segment decoder.
//
// Ports:
//   nibble_i  [3:0]  hex value to show
//   seg_o     [6:0]  active-low segment pattern {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Straight lookup of the hex glyph table; every nibble value is covered.
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan -- time-multiplexed driver for an 8-digit common-anode display.
//
// Each digit is lit for CLK_DIV clocks; a full frame is 8*CLK_DIV clocks.
// din is copied into a shadow register only when the digit index wraps
// 7->0, so one frame never mixes two din values.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din  [31:0] value to display, 8 hex nibbles (digit 0 = bits 3:0)
//   an   [7:0]  active-low digit anode enables
//   seg  [6:0]  active-low segments {g,f,e,d,c,b,a}
//   dp          decimal point, active-low, always off (1)
//   frame_tick  one-cycle pulse the cycle after each shadow reload
//
// Configuration:
//   SEG7_LZB_EN  when defined, digits above the most significant nonzero
//                nibble of the shadow are blanked (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam logic [PRESC_W-1:0] DIV_MAX = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  digit_idx_t            idx_q, idx_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  frame_q, frame_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q;
  seg_t                  dec_seg;
  nibble_t               cur_nib;
  logic                  tick;
  logic                  wrap;
  logic                  blank;

  // Prescaler, digit index and frame reload. The shadow is only touched on
  // the tick that takes the index from 7 back to 0.
  always_comb begin
    tick     = (presc_q == DIV_MAX);
    wrap     = tick && (idx_q == 3'd7);
    presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = wrap ? din : shadow_q;
    frame_d  = wrap;
    cur_nib  = shadow_q[{idx_q, 2'b00} +: 4];
  end

`ifdef SEG7_LZB_EN
  digit_idx_t msd;

  // Find the most significant nonzero nibble; digits above it stay dark.
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (shadow_q[4*i +: 4] != 4'h0) msd = digit_idx_t'(i);
    end
    blank = (idx_q > msd);
  end
`else
  assign blank = 1'b0;
`endif

  // One-hot active-low anode for the current slot.
  always_comb begin
    an_d = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  end

  seg7_decode u_decode (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  // All scan state and the display outputs are registered; outputs follow
  // the index/shadow with one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      frame_q  <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      an_q     <= an_d;
      seg_q    <= dec_seg;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter: CLK_DIV, 50000, clk cycles each digit is displayed (legal range 1..2^20).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: din  input  32  value from the GPIO output register, treated as raw bits (sign ignored).
REQ-005 SHALL have port: an  output  8  digit anode enables, active-low, bit i = digit i (digit 0 = least significant nibble).
REQ-006 SHALL have port: seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port: dp  output  1  decimal point, active-low, held at 1.
REQ-008 SHALL have port: frame_tick  output  1  one-cycle pulse marking a frame boundary and shadow reload.

Function
REQ-009 SHALL keep a prescaler counting 0..CLK_DIV-1 and wrapping to 0; tick = (prescaler == CLK_DIV-1).
REQ-010 SHALL advance a 3-bit digit index on each tick, 0->1->...->7->0.
REQ-011 SHALL load a 32-bit shadow register from din only on the tick where the index wraps 7->0, so a frame never mixes two din values.
REQ-012 SHALL assert frame_tick for exactly the cycle after that wrapping tick (registered), i.e. once per 8*CLK_DIV cycles.
REQ-013 SHALL register an and seg every cycle from the current index and shadow: an = ~(1<<index), seg = decode(shadow[4*index+3:4*index]); latency one cycle from index/shadow change.
REQ-014 SHALL decode hex 0..F as active-low patterns: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
REQ-015 SHALL, when CLK_DIV=1, advance the index every cycle with no other change in behaviour.
REQ-016 SHALL ignore din changes between frame boundaries; din changing on the reload cycle is captured as sampled at that edge.

Reset
REQ-017 SHALL on rst_n low, without waiting for clk, force an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, prescaler=0, index=0, shadow=0.
REQ-018 SHALL, on the first clk edge after rst_n release, drive an=8'hFE, seg=7'h40 (digit 0 showing 0).
REQ-019 SHALL restart a full frame from digit 0 after any reset, including one asserted mid-frame.

Configuration
REQ-020 SHALL support macro SEG7_LZB_EN (leading-zero blanking).
REQ-021 SHALL, with SEG7_LZB_EN defined, hold an at 8'hFF during the slot of every digit above the most significant nonzero nibble of shadow; digit 0 is always shown; slot timing is unchanged.
REQ-022 SHALL, without SEG7_LZB_EN, display all eight digits including leading zeros.

Structure
REQ-023 SHALL place NUM_DIGITS=8, the segment encoding constants of REQ-014 and the blank pattern 7'h7F in shared package seg7_pkg.
REQ-024 SHALL implement nibble-to-segment decoding in one combinational sub-module seg7_decode, instantiated once.

Verification (CLK_DIV=4)
REQ-025 Reset: hold rst_n=0 -> an=FF, seg=7F, frame_tick=0; release -> next edge an=FE, seg=40.
REQ-026 Load: din=32'h12345678 before frame boundary -> after frame_tick, digit 0 slot seg=00, digit 7 slot seg=79, an walks FE,FD,...,7F, 4 cycles each.
REQ-027 Tearing: change din from 32'h12345678 to 32'hFFFFFFFF while digit 3 is displayed -> digits 4..7 of that frame still show 4,3,2,1; next frame shows all 0E.
REQ-028 Timing: frame_tick high one cycle, period exactly 32 cycles, across at least 3 frames.
REQ-029 Blanking (SEG7_LZB_EN): shadow=32'h000000A5 -> digit 0 seg=12, digit 1 seg=08, an=FF during slots 2..7; shadow=0 -> only digit 0 shows 40.
REQ-030 Async reset: assert rst_n between edges while index=5 -> outputs at reset values immediately; after release frame restarts at digit 0 showing 0.
